// File: rtl/booth_mac_accumulator.sv
// Saturating signed accumulator for a stream of Booth-multiplier products.
// Sums each vector of beats and holds the result, beat count and sticky saturation flag until consumed.
module booth_mac_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat
);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    localparam logic signed [ACC_W:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};

    state_t                   state, state_nxt;
    logic signed [ACC_W-1:0]  acc, acc_nxt;
    logic signed [ACC_W:0]    sum;
    logic [CNT_W-1:0]         cnt, cnt_nxt;
    logic                     sat, sat_nxt;
    logic                     accept;

    // One guard bit above the accumulator is enough: a single product can never
    // push the sum past twice the accumulator range.
    function automatic logic is_ovf(input logic signed [ACC_W:0] s);
        return (s > ACC_MAX) || (s < ACC_MIN);
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_clamp(input logic signed [ACC_W:0] s);
        logic signed [ACC_W:0] r;
        if (s > ACC_MAX)
            r = ACC_MAX;
        else if (s < ACC_MIN)
            r = ACC_MIN;
        else
            r = s;
        return r[ACC_W-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ACCUM;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: if (accept && in_last) state_nxt = HOLD;
            HOLD:  if (out_ready)         state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = (state == ACCUM) && !rst;
        out_valid = (state == HOLD);
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        sum     = {acc[ACC_W-1], acc} + {{(ACC_W+1-PROD_W){in_prod[PROD_W-1]}}, in_prod};
        acc_nxt = sat_clamp(sum);
        sat_nxt = sat | is_ovf(sum);
        cnt_nxt = (&cnt) ? cnt : cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            out_acc   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else if (accept) begin
            if (in_last) begin
                out_acc   <= acc_nxt;
                out_count <= cnt_nxt;
                out_sat   <= sat_nxt;
                acc       <= '0;
                cnt       <= '0;
                sat       <= 1'b0;
            end else begin
                acc <= acc_nxt;
                cnt <= cnt_nxt;
                sat <= sat_nxt;
            end
        end
    end

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Bench for booth_mac_accumulator: directed vectors plus random traffic against
// a vector-level model that sums queued products with integer clamping.
module tb_booth_mac_accumulator;

    localparam longint MAXV = 64'sd8388607;
    localparam longint MINV = -64'sd8388608;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_prod = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_acc;
    logic [7:0]  out_count;
    logic        out_sat;

    int total = 0;
    int bad   = 0;

    longint vec[$];
    bit     m_hold = 0;
    longint m_acc  = 0;
    longint m_cnt  = 0;
    longint m_sat  = 0;

    booth_mac_accumulator #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_count(out_count), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Close out a vector: running sum clamped after every beat, sticky flag, capped count.
    function automatic void finish_vector();
        longint a = 0;
        longint s = 0;
        foreach (vec[i]) begin
            a = a + vec[i];
            if (a > MAXV) begin a = MAXV; s = 1; end
            if (a < MINV) begin a = MINV; s = 1; end
        end
        m_acc = a;
        m_sat = s;
        m_cnt = (vec.size() > 255) ? 255 : vec.size();
        vec.delete();
    endfunction

    task automatic cyc();
        bit acc_beat;
        bit consume;
        acc_beat = in_valid && !m_hold && !rst;
        consume  = out_ready && m_hold && !rst;
        @(posedge clk);
        #1;
        if (rst) begin
            vec.delete();
            m_hold = 0; m_acc = 0; m_cnt = 0; m_sat = 0;
        end else if (acc_beat) begin
            vec.push_back(longint'($signed(in_prod)));
            if (in_last) begin
                finish_vector();
                m_hold = 1;
            end
        end else if (consume) begin
            m_hold = 0;
        end
        check("in_ready", in_ready, (!m_hold && !rst) ? 1 : 0);
        check("out_valid", out_valid, m_hold ? 1 : 0);
        check("out_acc", longint'($signed(out_acc)), m_acc);
        check("out_count", out_count, m_cnt);
        check("out_sat", out_sat, m_sat);
    endtask

    task automatic beat(input int p, input bit last);
        in_valid = 1'b1;
        in_prod  = p[15:0];
        in_last  = last;
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        // reset
        cyc();
        check("rst_ready", in_ready, 0);
        check("rst_acc", out_acc, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", in_ready, 1);

        // single-beat vector, result held without out_ready
        beat(-42, 1);
        check("single_valid", out_valid, 1);
        check("single_acc", out_acc, 'hFFFFD6);
        check("single_cnt", out_count, 1);
        idle(2);
        check("single_hold_ready", in_ready, 0);
        out_ready = 1'b1;
        idle(1);
        check("single_consumed", out_valid, 0);

        // multi-beat vector with out_ready high
        beat(3, 0); beat(5, 0); beat(-10, 1);
        check("multi_acc", longint'($signed(out_acc)), -2);
        check("multi_cnt", out_count, 3);
        idle(1);
        check("multi_valid_1cyc", out_valid, 0);
        beat(7, 1);
        check("clear_acc", out_acc, 7);
        check("clear_cnt", out_count, 1);
        idle(1);

        // backpressure with in_valid held high
        out_ready = 1'b0;
        beat(100, 0); beat(200, 1);
        in_valid = 1'b1; in_prod = 16'd1; in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("bp_acc", out_acc, 300);
            check("bp_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        cyc();
        in_last = 1'b1;
        cyc();
        check("bp_restart_acc", out_acc, 1);
        check("bp_restart_cnt", out_count, 1);
        idle(1);

        // positive saturation
        for (int i = 0; i < 599; i++) beat(16384, 0);
        beat(16384, 1);
        check("psat_acc", out_acc, 8388607);
        check("psat_cnt", out_count, 255);
        check("psat_sat", out_sat, 1);
        idle(1);

        // negative saturation, sticky flag after recovering into range
        for (int i = 0; i < 520; i++) beat(-16256, 0);
        beat(16384, 1);
        check("nsat_acc", longint'($signed(out_acc)), -8372224);
        check("nsat_cnt", out_count, 255);
        check("nsat_sat", out_sat, 1);
        idle(1);

        // reset mid-vector
        beat(50, 0); beat(50, 0);
        rst = 1'b1;
        #1;
        check("midrst_ready", in_ready, 0);
        check("midrst_acc", out_acc, 0);
        check("midrst_cnt", out_count, 0);
        check("midrst_sat", out_sat, 0);
        cyc();
        rst = 1'b0;
        beat(7, 1);
        check("midrst_after_acc", out_acc, 7);
        check("midrst_after_cnt", out_count, 1);
        check("midrst_after_sat", out_sat, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int p;
            p = int'($urandom_range(0, 32640)) - 16256;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_prod   = p[15:0];
            in_last   = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 1) == 1);
            rst       = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
